// File: rtl/eu_event_collector.sv
// eu_event_collector: counts cycles with eu high and hands each batch
// to a consumer over a dav_/rfd handshake, then restarts from zero.
// Optional feature macro: COLLECTOR_OVF_EN. When it is defined, the
// accumulator saturates and the ovf output flags saturated batches.
// When it is undefined, the accumulator wraps and there is no ovf port.
module eu_event_collector #(
  parameter int W         = 8,
  parameter int MIN_BATCH = 1
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         eu,
  input  logic         rfd,
  output logic         dav_,
  output logic [W-1:0] data
`ifdef COLLECTOR_OVF_EN
  ,
  output logic         ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_OFFER   = 2'b01,
    S_RELEASE = 2'b10
  } state_t;

  localparam logic [W-1:0] MIN_W = W'(MIN_BATCH);

  state_t         state_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   data_q;
  logic           dav_q;
  logic [W-1:0]   acc_d;
  logic           snap_d;

`ifdef COLLECTOR_OVF_EN
  logic           sat_q;
  logic           ovf_q;
  logic           sat_hit_d;

  // Saturating accumulate; flag an event that arrives at full scale.
  always_comb begin
    sat_hit_d = (&acc_q) & eu;
    acc_d     = (&acc_q) ? acc_q : acc_q + W'(eu);
  end
`else
  // Wrapping accumulate.
  always_comb begin
    acc_d = acc_q + W'(eu);
  end
`endif

  // Snapshot when idle, consumer ready and the batch is large enough.
  // A wrapped-to-zero batch is never offered.
  always_comb begin
    snap_d = (state_q == S_IDLE) && rfd && (acc_q >= MIN_W);
`ifndef COLLECTOR_OVF_EN
    if (acc_d == '0) begin
      snap_d = 1'b0;
    end
`endif
  end

  // Accumulator, handshake FSM and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      data_q  <= '0;
      dav_q   <= 1'b1;
`ifdef COLLECTOR_OVF_EN
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      // Default: keep counting; the snapshot edge overrides acc and sat below
      // so the event seen at that edge goes into the batch, not the next one.
      acc_q <= acc_d;
`ifdef COLLECTOR_OVF_EN
      if (sat_hit_d) begin
        sat_q <= 1'b1;
      end
`endif
      case (state_q)
        S_IDLE: begin
          dav_q <= 1'b1;
          if (snap_d) begin
            data_q  <= acc_d;
            acc_q   <= '0;
            dav_q   <= 1'b0;
            state_q <= S_OFFER;
`ifdef COLLECTOR_OVF_EN
            ovf_q   <= sat_q | sat_hit_d;
            sat_q   <= 1'b0;
`endif
          end
        end
        S_OFFER: begin
          if (!rfd) begin
            dav_q   <= 1'b1;
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (rfd) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          dav_q   <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dav_ = dav_q;
  assign data = data_q;
`ifdef COLLECTOR_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_eu_event_collector.sv
// Self-checking bench for eu_event_collector (W=8). A second instance with
// MIN_BATCH=4 shares the stimulus and is checked in its own scenario.
module tb_eu_event_collector;

`ifdef COLLECTOR_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_ = 1'b0;
  logic       eu = 1'b0;
  logic       rfd = 1'b0;
  logic       dav_, dav4_;
  logic [7:0] data, data4;
  logic       ovf, ovf4;

  int tests = 0;
  int fails = 0;

  eu_event_collector #(.W(8), .MIN_BATCH(1)) dut (
    .clock(clock), .reset_(reset_), .eu(eu), .rfd(rfd),
    .dav_(dav_), .data(data)
`ifdef COLLECTOR_OVF_EN
    , .ovf(ovf)
`endif
  );

  eu_event_collector #(.W(8), .MIN_BATCH(4)) dut4 (
    .clock(clock), .reset_(reset_), .eu(eu), .rfd(rfd),
    .dav_(dav4_), .data(data4)
`ifdef COLLECTOR_OVF_EN
    , .ovf(ovf4)
`endif
  );

`ifndef COLLECTOR_OVF_EN
  assign ovf  = 1'b0;
  assign ovf4 = 1'b0;
`endif

  always #5 clock = ~clock;

  // Reference model: unbounded event count since the last batch, mapped to
  // the W-bit view by wrap or saturation.
  int m_pend  = 0;
  int m_phase = 0;   // 0 idle, 1 data offered, 2 waiting for consumer re-ready
  int m_data  = 0;
  bit m_ovf   = 0;
  bit m_dav   = 1;

  function automatic int view(input int n);
    if (OVF) return (n > 255) ? 255 : n;
    return n % 256;
  endfunction

  task automatic model_step(input bit e, input bit r, input bit rst);
    int v;
    if (!rst) begin
      m_pend = 0; m_phase = 0; m_data = 0; m_ovf = 0; m_dav = 1;
    end else if (m_phase == 0) begin
      v = view(m_pend + e);
      if (view(m_pend) >= 1 && r && (OVF || v != 0)) begin
        m_data = v; m_ovf = OVF && (m_pend + e > 255);
        m_pend = 0; m_phase = 1; m_dav = 0;
      end else begin
        m_pend = m_pend + e;
      end
    end else if (m_phase == 1) begin
      m_pend = m_pend + e;
      if (!r) begin m_phase = 2; m_dav = 1; end
    end else begin
      m_pend = m_pend + e;
      if (r) m_phase = 0;
    end
  endtask

  // One clock edge with the given inputs; outputs are sampled 1 time unit later.
  task automatic cycle(input bit e, input bit r, input bit rst);
    eu = e; rfd = r; reset_ = rst;
    @(posedge clock);
    model_step(e, r, rst);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    tests++;
    if (dav_ !== 1'b1 || data !== 8'd0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: dav_=%b data=%0d ovf=%b, want 1 0 0", dav_, data, ovf);
    end
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    tests++;
    if (dav_ !== 1'b1) begin
      fails++;
      $display("FAIL reset_no_offer: dav_=%b want 1", dav_);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
    tests++;
    if (dav_ !== 1'b1) begin
      fails++;
      $display("FAIL stall_hold: dav_=%b want 1", dav_);
    end
    cycle(1'b0, 1'b1, 1'b1);
    tests++;
    if (dav_ !== 1'b0 || data !== 8'd3) begin
      fails++;
      $display("FAIL stall_offer: dav_=%b data=%0d want 0 3", dav_, data);
    end
    cycle(1'b0, 1'b0, 1'b1);
    tests++;
    if (dav_ !== 1'b1 || data !== 8'd3) begin
      fails++;
      $display("FAIL stall_release: dav_=%b data=%0d want 1 3", dav_, data);
    end
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    tests++;
    if (dav_ !== 1'b1) begin
      fails++;
      $display("FAIL stall_back_idle: dav_=%b want 1", dav_);
    end
  endtask

  task automatic test_same_edge();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    tests++;
    if (dav_ !== 1'b0 || data !== 8'd5) begin
      fails++;
      $display("FAIL same_edge_data: dav_=%b data=%0d want 0 5", dav_, data);
    end
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    tests++;
    if (dav_ !== 1'b0 || data !== 8'd2) begin
      fails++;
      $display("FAIL same_edge_next: dav_=%b data=%0d want 0 2", dav_, data);
    end
  endtask

  task automatic test_carry();
    do_reset();
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    tests++;
    if (dav_ !== 1'b0 || data !== 8'd1) begin
      fails++;
      $display("FAIL carry_first: dav_=%b data=%0d want 0 1", dav_, data);
    end
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    tests++;
    if (dav_ !== 1'b0 || data !== 8'd1) begin
      fails++;
      $display("FAIL carry_held: dav_=%b data=%0d want 0 1", dav_, data);
    end
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    tests++;
    if (dav_ !== 1'b0 || data !== 8'd2) begin
      fails++;
      $display("FAIL carry_second: dav_=%b data=%0d want 0 2", dav_, data);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    tests++;
    if (dav_ !== 1'b0 || data !== (OVF ? 8'd255 : 8'd44) || ovf !== OVF) begin
      fails++;
      $display("FAIL overflow: dav_=%b data=%0d ovf=%b want 0 %0d %b",
               dav_, data, ovf, OVF ? 255 : 44, OVF);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    tests++;
    if (dav_ !== 1'b1 || data !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid: dav_=%b data=%0d want 1 0", dav_, data);
    end
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    tests++;
    if (dav_ !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_discard: dav_=%b want 1", dav_);
    end
  endtask

  task automatic test_min_batch();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    tests++;
    if (dav4_ !== 1'b1) begin
      fails++;
      $display("FAIL min_batch_three: dav_=%b want 1", dav4_);
    end
    cycle(1'b1, 1'b1, 1'b1);
    tests++;
    if (dav4_ !== 1'b1) begin
      fails++;
      $display("FAIL min_batch_fourth_edge: dav_=%b want 1", dav4_);
    end
    cycle(1'b0, 1'b1, 1'b1);
    tests++;
    if (dav4_ !== 1'b0 || data4 !== 8'd4) begin
      fails++;
      $display("FAIL min_batch_offer: dav_=%b data=%0d want 0 4", dav4_, data4);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit e, r, rst;
      e   = ($urandom_range(0, 99) < 60);
      r   = ($urandom_range(0, 99) < 55);
      rst = ($urandom_range(0, 199) != 0);
      // Occasional long stalls push the accumulator across full scale.
      if (i % 700 > 400 && i % 700 < 680) begin e = 1'b1; r = 1'b0; rst = 1'b1; end
      cycle(e, r, rst);
      tests++;
      if (dav_ !== m_dav || data !== 8'(m_data) || ovf !== m_ovf) begin
        fails++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: dav_=%b data=%0d ovf=%b want %b %0d %b",
                   i, dav_, data, ovf, m_dav, m_data, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_same_edge();
    test_carry();
    test_overflow();
    test_reset_mid();
    test_min_batch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
